// File: rtl/aq_djpeg_mcu_seq.sv
// MCU block sequencer: counts IDCT blocks into MCUs, runs an N-bank buffer ring and tags banks with MCU X/Y.
// Optional sticky protocol-error detection is built when AQ_DJPEG_MCU_SEQERR_EN is defined.
module aq_djpeg_mcu_seq #(
    parameter int WBITS = 12,
    parameter int BANKS = 2,
    parameter int BBITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ProcessInit,
    input  logic [1:0]       SampMode,
    input  logic [WBITS-1:0] McuWidth,
    input  logic [WBITS-1:0] McuHeight,
    input  logic             DataInEnable,
    input  logic [2:0]       DataInPage,
    input  logic [1:0]       DataInCount,
    output logic [2:0]       DataInColor,
    output logic [BBITS-1:0] DataInBank,
    output logic             DataInFull,
    output logic             ConvertValid,
    output logic [BBITS-1:0] ConvertBank,
    output logic [WBITS-1:0] ConvertMcuX,
    output logic [WBITS-1:0] ConvertMcuY,
    input  logic             ConvertDone,
    output logic             FrameDone,
    output logic             SeqError
);

    logic [BANKS-1:0] full_q, full_d;
    logic [BBITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [BBITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       color_q, color_d;
    logic [WBITS-1:0] wx_q, wx_d;
    logic [WBITS-1:0] wy_q, wy_d;
    logic [WBITS-1:0] tag_x_q [BANKS];
    logic [WBITS-1:0] tag_y_q [BANKS];
    logic             frame_done_q, frame_done_d;

    logic [2:0]       last_color;
    logic [WBITS-1:0] w_max, h_max;
    logic             word_end, block_end, mcu_done, release_bank;

    always_comb begin
        last_color = 3'd0;
        case (SampMode)
            2'd0: last_color = 3'd0;
            2'd1: last_color = 3'd2;
            2'd2: last_color = 3'd3;
            2'd3: last_color = 3'd5;
            default: last_color = 3'd0;
        endcase
    end

    // A zero dimension behaves as a single MCU along that axis.
    assign w_max = (McuWidth  == '0) ? '0 : McuWidth  - WBITS'(1);
    assign h_max = (McuHeight == '0) ? '0 : McuHeight - WBITS'(1);

    // Handshake: the writer may only complete a block while DataInFull is low;
    // a bank is handed to the converter while ConvertValid is high and is
    // returned by a ConvertDone pulse seen with ConvertValid still high.
    assign DataInFull   = &full_q;
    assign ConvertValid = full_q[rd_ptr_q];
    assign ConvertBank  = rd_ptr_q;
    assign ConvertMcuX  = tag_x_q[rd_ptr_q];
    assign ConvertMcuY  = tag_y_q[rd_ptr_q];
    assign DataInColor  = color_q;
    assign DataInBank   = wr_ptr_q;
    assign FrameDone    = frame_done_q;

    assign word_end     = DataInEnable && (DataInPage == 3'd7) && (DataInCount == 2'd3);
    assign block_end    = word_end && !DataInFull;
    assign mcu_done     = block_end && (color_q >= last_color);
    assign release_bank = ConvertDone && ConvertValid;

    always_comb begin
        full_d       = full_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        color_d      = color_q;
        wx_d         = wx_q;
        wy_d         = wy_q;
        frame_done_d = 1'b0;
        if (block_end) begin
            if (mcu_done) begin
                color_d          = 3'd0;
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = wr_ptr_q + BBITS'(1);
                if (wx_q >= w_max) begin
                    wx_d = '0;
                    wy_d = (wy_q >= h_max) ? '0 : wy_q + WBITS'(1);
                end else begin
                    wx_d = wx_q + WBITS'(1);
                end
            end else begin
                color_d = color_q + 3'd1;
            end
        end
        // The write and read banks cannot coincide here: equal pointers with
        // a valid release would mean every bank is full, blocking block_end.
        if (release_bank) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + BBITS'(1);
            frame_done_d     = (tag_x_q[rd_ptr_q] == w_max) && (tag_y_q[rd_ptr_q] == h_max);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            color_q      <= '0;
            wx_q         <= '0;
            wy_q         <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < BANKS; i++) begin
                tag_x_q[i] <= '0;
                tag_y_q[i] <= '0;
            end
        end else if (ProcessInit) begin
            full_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            color_q      <= '0;
            wx_q         <= '0;
            wy_q         <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < BANKS; i++) begin
                tag_x_q[i] <= '0;
                tag_y_q[i] <= '0;
            end
        end else begin
            full_q       <= full_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            color_q      <= color_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            frame_done_q <= frame_done_d;
            if (mcu_done) begin
                tag_x_q[wr_ptr_q] <= wx_q;
                tag_y_q[wr_ptr_q] <= wy_q;
            end
        end
    end

`ifdef AQ_DJPEG_MCU_SEQERR_EN
    logic seq_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_err_q <= 1'b0;
        end else if (ProcessInit) begin
            seq_err_q <= 1'b0;
        end else if ((word_end && DataInFull) || (ConvertDone && !ConvertValid)) begin
            seq_err_q <= 1'b1;
        end
    end

    assign SeqError = seq_err_q;
`else
    assign SeqError = 1'b0;
`endif

endmodule

// File: tb/tb_aq_djpeg_mcu_seq.sv
// Directed bench for aq_djpeg_mcu_seq (BANKS=2) with hand-computed expectations.
module tb_aq_djpeg_mcu_seq;

    localparam int WBITS = 12;
    localparam int BANKS = 2;
    localparam int BBITS = 1;

`ifdef AQ_DJPEG_MCU_SEQERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ProcessInit = 1'b0;
    logic [1:0]       SampMode = 2'd0;
    logic [WBITS-1:0] McuWidth = '0;
    logic [WBITS-1:0] McuHeight = '0;
    logic             DataInEnable = 1'b0;
    logic [2:0]       DataInPage = 3'd0;
    logic [1:0]       DataInCount = 2'd0;
    logic [2:0]       DataInColor;
    logic [BBITS-1:0] DataInBank;
    logic             DataInFull;
    logic             ConvertValid;
    logic [BBITS-1:0] ConvertBank;
    logic [WBITS-1:0] ConvertMcuX;
    logic [WBITS-1:0] ConvertMcuY;
    logic             ConvertDone = 1'b0;
    logic             FrameDone;
    logic             SeqError;

    int errors = 0;
    int checks = 0;
    int frame_pulses;

    aq_djpeg_mcu_seq #(.WBITS(WBITS), .BANKS(BANKS), .BBITS(BBITS)) dut (
        .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .SampMode(SampMode),
        .McuWidth(McuWidth), .McuHeight(McuHeight), .DataInEnable(DataInEnable),
        .DataInPage(DataInPage), .DataInCount(DataInCount), .DataInColor(DataInColor),
        .DataInBank(DataInBank), .DataInFull(DataInFull), .ConvertValid(ConvertValid),
        .ConvertBank(ConvertBank), .ConvertMcuX(ConvertMcuX), .ConvertMcuY(ConvertMcuY),
        .ConvertDone(ConvertDone), .FrameDone(FrameDone), .SeqError(SeqError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_block_end();
        DataInEnable = 1'b1;
        DataInPage   = 3'd7;
        DataInCount  = 2'd3;
    endtask

    task automatic feed_block();
        set_block_end();
        cyc();
        DataInEnable = 1'b0;
    endtask

    task automatic release_bank();
        ConvertDone = 1'b1;
        cyc();
        ConvertDone = 1'b0;
    endtask

    task automatic init_frame(input logic [1:0] mode, input int w, input int h);
        SampMode    = mode;
        McuWidth    = WBITS'(w);
        McuHeight   = WBITS'(h);
        ProcessInit = 1'b1;
        cyc();
        ProcessInit = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_color"}, 32'(DataInColor), 0);
        check({tag, "_wbank"}, 32'(DataInBank), 0);
        check({tag, "_full"},  32'(DataInFull), 0);
        check({tag, "_valid"}, 32'(ConvertValid), 0);
        check({tag, "_rbank"}, 32'(ConvertBank), 0);
        check({tag, "_x"},     32'(ConvertMcuX), 0);
        check({tag, "_y"},     32'(ConvertMcuY), 0);
        check({tag, "_frame"}, 32'(FrameDone), 0);
        check({tag, "_err"},   32'(SeqError), 0);
    endtask

    initial begin
        // Reset
        repeat (2) cyc();
        check_all_zero("reset");
        rst = 1'b1;
        cyc();

        // 4:2:0, 2x1 MCUs
        init_frame(2'd3, 2, 1);
        DataInEnable = 1'b1; DataInPage = 3'd7; DataInCount = 2'd2;
        cyc();
        DataInEnable = 1'b0;
        check("t1_nonend_word", 32'(DataInColor), 0);
        for (int i = 0; i < 6; i++) begin
            check("t1_color_seq", 32'(DataInColor), 32'(i));
            feed_block();
        end
        check("t1_color_wrap", 32'(DataInColor), 0);
        check("t1_valid", 32'(ConvertValid), 1);
        check("t1_x0", 32'(ConvertMcuX), 0);
        check("t1_y0", 32'(ConvertMcuY), 0);
        check("t1_wbank1", 32'(DataInBank), 1);
        check("t1_notfull", 32'(DataInFull), 0);
        repeat (6) feed_block();
        check("t1_full", 32'(DataInFull), 1);
        check("t1_wbank_wrap", 32'(DataInBank), 0);
        release_bank();
        check("t1_frame_early", 32'(FrameDone), 0);
        check("t1_rbank1", 32'(ConvertBank), 1);
        check("t1_x1", 32'(ConvertMcuX), 1);
        check("t1_y1", 32'(ConvertMcuY), 0);
        check("t1_full_drop", 32'(DataInFull), 0);
        release_bank();
        check("t1_frame_pulse", 32'(FrameDone), 1);
        check("t1_valid_gone", 32'(ConvertValid), 0);
        cyc();
        check("t1_frame_one_cycle", 32'(FrameDone), 0);

        // Gray, 3x2 MCUs, released as soon as valid
        init_frame(2'd0, 3, 2);
        frame_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            feed_block();
            check("t2_color", 32'(DataInColor), 0);
            check("t2_valid", 32'(ConvertValid), 1);
            check("t2_tag_x", 32'(ConvertMcuX), 32'(i % 3));
            check("t2_tag_y", 32'(ConvertMcuY), 32'(i / 3));
            release_bank();
            if (FrameDone) frame_pulses++;
            check("t2_frame_at", 32'(FrameDone), (i == 5) ? 32'd1 : 32'd0);
        end
        cyc();
        check("t2_frame_count", 32'(frame_pulses), 1);
        check("t2_frame_low", 32'(FrameDone), 0);
        feed_block();
        check("t2_wrap_x", 32'(ConvertMcuX), 0);
        check("t2_wrap_y", 32'(ConvertMcuY), 0);
        release_bank();
        check("t2_no_frame", 32'(FrameDone), 0);

        // 4:4:4 full stall
        init_frame(2'd1, 4, 4);
        repeat (6) feed_block();
        check("t3_full", 32'(DataInFull), 1);
        check("t3_err_before", 32'(SeqError), 0);
        feed_block();
        check("t3_color_hold", 32'(DataInColor), 0);
        check("t3_wbank_hold", 32'(DataInBank), 0);
        check("t3_rbank_hold", 32'(ConvertBank), 0);
        check("t3_tag_hold", 32'(ConvertMcuX), 0);
        check("t3_still_full", 32'(DataInFull), 1);
        check("t3_seqerr", 32'(SeqError), 32'(EXP_ERR));
        release_bank();
        check("t3_after_rel_x", 32'(ConvertMcuX), 1);

        // 4:2:2 simultaneous complete and release
        init_frame(2'd2, 2, 2);
        check("t4_err_cleared", 32'(SeqError), 0);
        repeat (7) feed_block();
        check("t4_color3", 32'(DataInColor), 3);
        set_block_end();
        ConvertDone = 1'b1;
        cyc();
        DataInEnable = 1'b0;
        ConvertDone  = 1'b0;
        check("t4_valid", 32'(ConvertValid), 1);
        check("t4_notfull", 32'(DataInFull), 0);
        check("t4_rbank", 32'(ConvertBank), 1);
        check("t4_x", 32'(ConvertMcuX), 1);
        check("t4_y", 32'(ConvertMcuY), 0);
        check("t4_wbank", 32'(DataInBank), 0);
        check("t4_color0", 32'(DataInColor), 0);
        check("t4_no_err", 32'(SeqError), 0);
        release_bank();
        check("t4_empty", 32'(ConvertValid), 0);
        release_bank();
        check("t4_ignored_rbank", 32'(ConvertBank), 0);
        check("t4_ignored_err", 32'(SeqError), 32'(EXP_ERR));

        // ProcessInit overrides a block end and a release in the same cycle
        init_frame(2'd3, 4, 4);
        repeat (8) feed_block();
        check("t5_valid_pre", 32'(ConvertValid), 1);
        check("t5_color_pre", 32'(DataInColor), 2);
        set_block_end();
        ConvertDone = 1'b1;
        ProcessInit = 1'b1;
        cyc();
        DataInEnable = 1'b0;
        ConvertDone  = 1'b0;
        ProcessInit  = 1'b0;
        check_all_zero("t5_init");

        // Asynchronous reset between edges
        repeat (7) feed_block();
        check("t5_valid_pre_rst", 32'(ConvertValid), 1);
        check("t5_color_pre_rst", 32'(DataInColor), 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t5_async");
        cyc();
        rst = 1'b1;
        cyc();
        feed_block();
        check("t5_after_rst", 32'(DataInColor), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
